// File: rtl/text_overlay_scroll.sv
// Cell-aligned 1-bpp text overlay with frame-paced wrap-around horizontal scroll and blink.
// One registered pixel per clock; lookup always uses the pre-update scroll offset and blink phase.
module text_overlay_scroll #(
   parameter int TEXT_W        = 60,
   parameter int TEXT_H        = 10,
   parameter int CELL_SHIFT    = 3,
   parameter int ORIGIN_X      = 11,
   parameter int ORIGIN_Y      = 38,
   parameter logic [TEXT_W*TEXT_H-1:0] BITMAP = '0,
   parameter int SCROLL_FRAMES = 2,
   parameter int BLINK_FRAMES  = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic       frame_start,
   input  logic       enable,
   input  logic [1:0] mode,
   output logic       overlay_active,
   output logic [6:0] scroll_off
);

   localparam int NBITS  = TEXT_W * TEXT_H;
   localparam int IDX_W  = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam int SCNT_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
   localparam int BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic signed [11:0] TEXT_W_S  = 12'(TEXT_W);
   localparam logic signed [11:0] TEXT_H_S  = 12'(TEXT_H);
   localparam logic signed [11:0] ORIGIN_XS = 12'(ORIGIN_X);
   localparam logic signed [11:0] ORIGIN_YS = 12'(ORIGIN_Y);
   localparam logic [7:0]         TEXT_W_8  = 8'(TEXT_W);
   localparam logic [6:0]         OFF_LAST  = 7'(TEXT_W - 1);
   localparam logic [SCNT_W-1:0]  SCNT_LAST = SCNT_W'(SCROLL_FRAMES - 1);
   localparam logic [BCNT_W-1:0]  BCNT_LAST = BCNT_W'(BLINK_FRAMES - 1);

   logic [NBITS-1:0] bitmap_w;
   assign bitmap_w = BITMAP;

   logic              overlay_q,     overlay_d;
   logic [6:0]        scroll_off_q,  scroll_off_d;
   logic [SCNT_W-1:0] scroll_cnt_q,  scroll_cnt_d;
   logic [BCNT_W-1:0] blink_cnt_q,   blink_cnt_d;
   logic              blink_phase_q, blink_phase_d;

   logic signed [11:0] cx;
   logic signed [11:0] cy;
   logic               in_win;
   logic [7:0]         col_sum;
   logic [7:0]         col;
   logic [13:0]        idx;
   logic               bit_sel;

   // Window test and wrapped column lookup
   always_comb begin
      cx      = $signed(12'(x >> CELL_SHIFT)) - ORIGIN_XS;
      cy      = $signed(12'(y >> CELL_SHIFT)) - ORIGIN_YS;
      in_win  = !cx[11] && (cx < TEXT_W_S) && !cy[11] && (cy < TEXT_H_S);
      col_sum = {1'b0, cx[6:0]} + {1'b0, scroll_off_q};
      col     = (col_sum >= TEXT_W_8) ? (col_sum - TEXT_W_8) : col_sum;
      idx     = (14'(cy[5:0]) * 14'(TEXT_W)) + 14'(col);
      bit_sel = in_win ? bitmap_w[idx[IDX_W-1:0]] : 1'b0;
   end

   always_comb begin
      overlay_d = enable & in_win & ~(mode[1] & blink_phase_q) & bit_sel;
   end

   always_comb begin
      scroll_cnt_d = scroll_cnt_q;
      scroll_off_d = scroll_off_q;
      if (frame_start && mode[0]) begin
         if (scroll_cnt_q == SCNT_LAST) begin
            scroll_cnt_d = '0;
            scroll_off_d = (scroll_off_q == OFF_LAST) ? 7'd0 : scroll_off_q + 7'd1;
         end else begin
            scroll_cnt_d = scroll_cnt_q + 1'b1;
         end
      end
   end

   // Blink state is dropped as soon as blink is disabled, so re-enabling starts a fresh on-phase
   always_comb begin
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (!mode[1]) begin
         blink_cnt_d   = '0;
         blink_phase_d = 1'b0;
      end else if (frame_start) begin
         if (blink_cnt_q == BCNT_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         overlay_q     <= 1'b0;
         scroll_off_q  <= '0;
         scroll_cnt_q  <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
      end else begin
         overlay_q     <= overlay_d;
         scroll_off_q  <= scroll_off_d;
         scroll_cnt_q  <= scroll_cnt_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
      end
   end

   assign overlay_active = overlay_q;
   assign scroll_off     = scroll_off_q;

endmodule

// File: tb/tb_text_overlay_scroll.sv
// Directed bench for text_overlay_scroll: static lookup, window edges, scroll, freeze, enable, blink, reset.
module tb_text_overlay_scroll;

   localparam int TW = 60;
   localparam int TH = 10;
   localparam int SF = 2;
   localparam int BF = 32;

   function automatic logic [TW*TH-1:0] make_bmp();
      logic [TW*TH-1:0] b;
      b = '0;
      for (int r = 0; r < TH; r++)
         for (int c = 0; c < TW; c++)
            b[r*TW+c] = (((c*5 + r*3) % 7) < 3);
      return b;
   endfunction

   localparam logic [TW*TH-1:0] BMP = make_bmp();

   logic       clk;
   logic       rst;
   logic [9:0] x;
   logic [9:0] y;
   logic       frame_start;
   logic       enable;
   logic [1:0] mode;
   logic       overlay_active;
   logic [6:0] scroll_off;

   int n_assert = 0;
   int n_fail   = 0;

   int soff_m, scnt_m, bcnt_m;
   logic phase_m;

   text_overlay_scroll #(
      .TEXT_W(TW), .TEXT_H(TH), .CELL_SHIFT(3), .ORIGIN_X(11), .ORIGIN_Y(38),
      .BITMAP(BMP), .SCROLL_FRAMES(SF), .BLINK_FRAMES(BF)
   ) dut (
      .clk(clk), .rst(rst), .x(x), .y(y), .frame_start(frame_start),
      .enable(enable), .mode(mode), .overlay_active(overlay_active), .scroll_off(scroll_off)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic logic raw_bit(input int xi, input int yi);
      int cxi, cyi, coli;
      logic [9:0] bi;
      cxi = (xi >> 3) - 11;
      cyi = (yi >> 3) - 38;
      if (cxi < 0 || cxi >= TW || cyi < 0 || cyi >= TH) return 1'b0;
      coli = (cxi + soff_m) % TW;
      bi = 10'(cyi*TW + coli);
      return BMP[bi];
   endfunction

   function automatic logic exp_pix(input int xi, input int yi);
      return enable & ~(mode[1] & phase_m) & raw_bit(xi, yi);
   endfunction

   function automatic int find_lit_x();
      for (int c = 0; c < TW; c++)
         if (raw_bit((11 + c) * 8, 304)) return (11 + c) * 8;
      return 88;
   endfunction

   task automatic model_reset();
      soff_m = 0; scnt_m = 0; bcnt_m = 0; phase_m = 1'b0;
   endtask

   task automatic model_frame();
      if (mode[0]) begin
         if (scnt_m == SF - 1) begin
            scnt_m = 0;
            soff_m = (soff_m + 1) % TW;
         end else scnt_m++;
      end
      if (mode[1]) begin
         if (bcnt_m == BF - 1) begin
            bcnt_m = 0;
            phase_m = ~phase_m;
         end else bcnt_m++;
      end else begin
         bcnt_m = 0; phase_m = 1'b0;
      end
   endtask

   task automatic set_mode(input logic [1:0] m);
      mode = m;
      if (!m[1]) begin bcnt_m = 0; phase_m = 1'b0; end
   endtask

   task automatic frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      model_frame();
   endtask

   task automatic pix(input string tag, input int xi, input int yi);
      x = 10'(xi);
      y = 10'(yi);
      tick();
      check(tag, 32'(overlay_active), 32'(exp_pix(xi, yi)));
   endtask

   initial begin
      int lx;
      logic e;
      rst = 1'b1; x = '0; y = '0; frame_start = 1'b0; enable = 1'b1; mode = 2'b00;
      model_reset();
      tick(); tick();
      check("reset_overlay", 32'(overlay_active), 32'd0);
      check("reset_scroll", 32'(scroll_off), 32'd0);
      rst = 1'b0;

      // static image
      for (int i = 88; i < 96; i++) begin
         x = 10'(i); y = 10'd304; tick();
         check("static_cell0", 32'(overlay_active), 32'(BMP[0]));
      end
      pix("static_c1", 96, 304);
      pix("static_r3c5", 88 + 8*5, 304 + 8*3);
      pix("static_r9c59", 88 + 8*59, 304 + 8*9);
      pix("outside_x568", 8*71, 304);
      pix("lit_before_edge", 88, 304);
      pix("edge_cx_m1", 80, 304);
      pix("edge_cy_m1", 88, 303);
      pix("edge_cy_h", 88, 384);
      check("edge_x568_lit", 32'(overlay_active), 32'd0);

      // scroll through a full wrap
      set_mode(2'b01);
      for (int i = 0; i < 120; i++) begin
         x = 10'd0; y = 10'd0;
         frame();
         check("scroll_off", 32'(scroll_off), 32'(soff_m));
         if (i == 117) check("scroll_59", 32'(scroll_off), 32'd59);
         if (i % 7 == 0) pix("scroll_pix", 88, 304 + 8*(i % 10));
      end
      check("scroll_wrap", 32'(scroll_off), 32'd0);

      // lookup coincident with a scroll step uses the old offset
      frame();
      x = 10'd88; y = 10'd304;
      e = exp_pix(88, 304);
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      model_frame();
      check("same_clk_lookup", 32'(overlay_active), 32'(e));
      check("same_clk_off", 32'(scroll_off), 32'd1);

      // freeze at offset 17
      for (int i = 0; i < 200 && !(soff_m == 17 && scnt_m == 0); i++) frame();
      check("freeze_reach", 32'(scroll_off), 32'd17);
      set_mode(2'b00);
      for (int i = 0; i < 10; i++) begin
         frame();
         check("freeze_hold", 32'(scroll_off), 32'd17);
      end
      pix("freeze_pix0", 88, 304);
      pix("freeze_pix1", 96, 304);

      // enable=0 blanks output while scroll keeps moving
      enable = 1'b0;
      set_mode(2'b01);
      for (int i = 0; i < 4; i++) begin
         frame();
         check("en_scroll", 32'(scroll_off), 32'(soff_m));
         pix("en_blank", find_lit_x(), 304);
      end
      check("en_off19", 32'(scroll_off), 32'd19);
      enable = 1'b1;

      // blink
      set_mode(2'b10);
      lx = find_lit_x();
      pix("blink_on0", lx, 304);
      for (int i = 0; i < 31; i++) frame();
      pix("blink_on31", lx, 304);
      frame();
      pix("blink_off32", lx, 304);
      check("blink_off_lit", 32'(overlay_active), 32'd0);
      pix("blink_off_other", 88 + 8*3, 304 + 8*2);
      for (int i = 0; i < 32; i++) frame();
      pix("blink_on64", lx, 304);
      check("blink_restored", 32'(overlay_active), 32'd1);
      for (int i = 0; i < 32; i++) frame();
      pix("blink_off96", lx, 304);
      x = 10'(lx); y = 10'd304;
      set_mode(2'b00);
      tick();
      check("blink_clear_reappear", 32'(overlay_active), 32'd1);
      check("blink_clear_off", 32'(scroll_off), 32'd19);

      // reset with scroll_off=30 and blink phase set
      rst = 1'b1; tick(); rst = 1'b0;
      model_reset();
      set_mode(2'b11);
      x = 10'd0; y = 10'd0;
      for (int i = 0; i < 60; i++) frame();
      check("pre_rst_off", 32'(scroll_off), 32'd30);
      pix("pre_rst_blink", find_lit_x(), 304);
      x = 10'd88; y = 10'd304;
      rst = 1'b1; frame_start = 1'b1;
      tick();
      check("rst_overlay", 32'(overlay_active), 32'd0);
      check("rst_scroll", 32'(scroll_off), 32'd0);
      tick();
      check("rst_fs_ignored", 32'(scroll_off), 32'd0);
      rst = 1'b0; frame_start = 1'b0;
      model_reset();
      set_mode(2'b00);
      pix("post_rst_static", 88, 304);
      check("post_rst_lit", 32'(overlay_active), 32'd1);
      set_mode(2'b01);
      frame();
      check("post_rst_cnt0", 32'(scroll_off), 32'd0);
      frame();
      check("post_rst_step", 32'(scroll_off), 32'd1);
      set_mode(2'b10);
      frame();
      pix("post_rst_phase0", 88, 304);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
